// File: rtl/dmem_axi_responder_pkg.sv
// Shared types and constants for the dmem AXI4-Lite responder.
package dmem_axi_responder_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        W_RESP = 2'd1,
        R_RESP = 2'd2
    } dmem_resp_state_t;

endpackage

// File: rtl/dmem_sram.sv
// Single-port data SRAM: 1-cycle synchronous read, per-byte write enables, no reset.
module dmem_sram
    import dmem_axi_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter string       INIT_FILE   = "",
    localparam int unsigned ADDR_W     = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  re_i,
    input  logic [AXI_STRB_W-1:0] we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [AXI_DATA_W-1:0] wdata_i,
    output logic [AXI_DATA_W-1:0] rdata_o
);

    logic [AXI_DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [AXI_DATA_W-1:0] rdata_q;

    // Preload images are attached by the simulation/FPGA memory-init flow.
    if (INIT_FILE != "") begin : g_preload
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(AXI_STRB_W); b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_axi_responder.sv
// AXI4-Lite responder owning the data SRAM; one write or read outstanding,
// round-robin between requestable write and read.
module dmem_axi_responder
    import dmem_axi_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter string       INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AXI_ADDR_W-1:0] dmem_axi_awaddr,
    input  logic                  dmem_axi_awvalid,
    output logic                  dmem_axi_awready,
    input  logic [AXI_DATA_W-1:0] dmem_axi_wdata,
    input  logic [AXI_STRB_W-1:0] dmem_axi_wstrb,
    input  logic                  dmem_axi_wvalid,
    output logic                  dmem_axi_wready,
    output logic [1:0]            dmem_axi_bresp,
    output logic                  dmem_axi_bvalid,
    input  logic                  dmem_axi_bready,
    input  logic [AXI_ADDR_W-1:0] dmem_axi_araddr,
    input  logic                  dmem_axi_arvalid,
    output logic                  dmem_axi_arready,
    output logic [AXI_DATA_W-1:0] dmem_axi_rdata,
    output logic [1:0]            dmem_axi_rresp,
    output logic                  dmem_axi_rvalid,
    input  logic                  dmem_axi_rready
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [AXI_ADDR_W:0] SPAN = (AXI_ADDR_W+1)'(DEPTH_WORDS) << 2;

    dmem_resp_state_t state_q, state_d;
    logic             rr_last_q, rr_last_d;
    logic [1:0]       bresp_q, bresp_d;
    logic [1:0]       rresp_q, rresp_d;

    logic [AXI_ADDR_W-1:0] aw_off, ar_off;
    logic                  aw_in_range, ar_in_range;
    logic                  grant_w_c, grant_r_c;
    logic                  sram_re;
    logic [AXI_STRB_W-1:0] sram_we;
    logic [IDX_W-1:0]      sram_idx;
    logic [AXI_DATA_W-1:0] sram_rdata;

    // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land out of range.
    assign aw_off      = dmem_axi_awaddr - BASE_ADDR;
    assign ar_off      = dmem_axi_araddr - BASE_ADDR;
    assign aw_in_range = {1'b0, aw_off} < SPAN;
    assign ar_in_range = {1'b0, ar_off} < SPAN;

    // Grants only in IDLE and out of reset; rr_last=1 hands a conflict to the read.
    always_comb begin
        grant_w_c = 1'b0;
        grant_r_c = 1'b0;
        if (reset && (state_q == IDLE)) begin
            grant_w_c = dmem_axi_awvalid && dmem_axi_wvalid
                        && (!dmem_axi_arvalid || !rr_last_q);
            grant_r_c = dmem_axi_arvalid
                        && (!(dmem_axi_awvalid && dmem_axi_wvalid) || rr_last_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        sram_re   = 1'b0;
        sram_we   = '0;
        sram_idx  = ar_off[IDX_W+1:2];
        case (state_q)
            IDLE: begin
                if (grant_w_c) begin
                    state_d   = W_RESP;
                    rr_last_d = 1'b1;
                    sram_idx  = aw_off[IDX_W+1:2];
                    sram_we   = aw_in_range ? dmem_axi_wstrb : '0;
                    bresp_d   = aw_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                end else if (grant_r_c) begin
                    state_d   = R_RESP;
                    rr_last_d = 1'b0;
                    sram_re   = ar_in_range;
                    rresp_d   = ar_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (dmem_axi_bready) begin
                    state_d = IDLE;
                end
            end
            R_RESP: begin
                if (dmem_axi_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            bresp_q   <= AXI_RESP_OKAY;
            rresp_q   <= AXI_RESP_OKAY;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
        end
    end

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE)
    ) u_sram (
        .clk     (clk),
        .re_i    (sram_re),
        .we_i    (sram_we),
        .addr_i  (sram_idx),
        .wdata_i (dmem_axi_wdata),
        .rdata_o (sram_rdata)
    );

    assign dmem_axi_awready = grant_w_c;
    assign dmem_axi_wready  = grant_w_c;
    assign dmem_axi_arready = grant_r_c;
    assign dmem_axi_bvalid  = (state_q == W_RESP);
    assign dmem_axi_rvalid  = (state_q == R_RESP);
    assign dmem_axi_bresp   = bresp_q;
    assign dmem_axi_rresp   = rresp_q;
    // SRAM output is untouched in R_RESP, so rdata holds until rready.
    assign dmem_axi_rdata   = ((state_q == R_RESP) && (rresp_q == AXI_RESP_OKAY))
                              ? sram_rdata : '0;

endmodule

// File: tb/tb_dmem_axi_responder.sv
// Scoreboard bench for dmem_axi_responder: expected responses queued at drive time.
`timescale 1ns/1ps
module tb_dmem_axi_responder;

    localparam int unsigned DEPTH   = 4096;
    localparam logic [31:0] BASE    = 32'h0000_0000;
    localparam int          TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    dmem_axi_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH),
        .INIT_FILE   ("")
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .dmem_axi_awaddr  (awaddr),
        .dmem_axi_awvalid (awvalid),
        .dmem_axi_awready (awready),
        .dmem_axi_wdata   (wdata),
        .dmem_axi_wstrb   (wstrb),
        .dmem_axi_wvalid  (wvalid),
        .dmem_axi_wready  (wready),
        .dmem_axi_bresp   (bresp),
        .dmem_axi_bvalid  (bvalid),
        .dmem_axi_bready  (bready),
        .dmem_axi_araddr  (araddr),
        .dmem_axi_arvalid (arvalid),
        .dmem_axi_arready (arready),
        .dmem_axi_rdata   (rdata),
        .dmem_axi_rresp   (rresp),
        .dmem_axi_rvalid  (rvalid),
        .dmem_axi_rready  (rready)
    );

    typedef struct { bit is_w; logic [1:0] resp; logic [31:0] data; } exp_t;
    typedef struct { bit to; int lat; logic [1:0] resp; logic [31:0] data; } obs_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [int unsigned];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic bit in_range(input logic [31:0] a);
        logic [31:0] off = a - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        int unsigned r = (a - BASE) >> 2;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t        e;
        logic [31:0] w;
        e.is_w = 1'b1;
        e.data = 32'h0;
        if (in_range(a)) begin
            w = model_mem.exists(widx(a)) ? model_mem[widx(a)] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            model_mem[widx(a)] = w;
            e.resp = 2'b00;
        end else begin
            e.resp = 2'b10;
        end
        sb_q.push_back(e);
    endtask

    task automatic push_read(input logic [31:0] a);
        exp_t e;
        e.is_w = 1'b0;
        if (in_range(a)) begin
            e.resp = 2'b00;
            e.data = model_mem.exists(widx(a)) ? model_mem[widx(a)] : 32'h0;
        end else begin
            e.resp = 2'b10;
            e.data = 32'h0;
        end
        sb_q.push_back(e);
    endtask

    task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output bit to);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        to = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            if (awready && wready) begin
                tick();
                to = 1'b0;
                break;
            end
            tick();
        end
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic issue_read(input logic [31:0] a, output bit to);
        araddr = a; arvalid = 1'b1;
        to = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            if (arready) begin
                tick();
                to = 1'b0;
                break;
            end
            tick();
        end
        arvalid = 1'b0;
    endtask

    task automatic collect_b(output obs_t o);
        o.to = 1'b1; o.lat = 0; o.resp = 2'bxx; o.data = 32'h0;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (bvalid) begin
                o.resp = bresp;
                o.to   = 1'b0;
                break;
            end
            tick();
            o.lat++;
        end
        if (!o.to) begin
            bready = 1'b1;
            tick();
            bready = 1'b0;
        end
    endtask

    task automatic collect_r(output obs_t o);
        o.to = 1'b1; o.lat = 0; o.resp = 2'bxx; o.data = 32'hx;
        for (int i = 0; i < TIMEOUT; i++) begin
            if (rvalid) begin
                o.resp = rresp;
                o.data = rdata;
                o.to   = 1'b0;
                break;
            end
            tick();
            o.lat++;
        end
        if (!o.to) begin
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output obs_t o, output exp_t e);
        bit to_i;
        push_write(a, d, s);
        issue_write(a, d, s, to_i);
        collect_b(o);
        o.to = o.to | to_i;
        e = sb_q.pop_front();
    endtask

    task automatic do_read(input logic [31:0] a, output obs_t o, output exp_t e);
        bit to_i;
        push_read(a);
        issue_read(a, to_i);
        collect_r(o);
        o.to = o.to | to_i;
        e = sb_q.pop_front();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        awaddr = 32'h10; araddr = 32'h10; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick(); tick();
        n_cmp++; if (awready !== 1'b0) begin n_err++; $display("FAIL reset_awready: got %b want 0", awready); end
        n_cmp++; if (wready !== 1'b0) begin n_err++; $display("FAIL reset_wready: got %b want 0", wready); end
        n_cmp++; if (arready !== 1'b0) begin n_err++; $display("FAIL reset_arready: got %b want 0", arready); end
        n_cmp++; if ({bvalid, rvalid} !== 2'b00) begin n_err++; $display("FAIL reset_valids: got %b want 00", {bvalid, rvalid}); end
        n_cmp++; if ({bresp, rresp} !== 4'b0000) begin n_err++; $display("FAIL reset_resps: got %b want 0000", {bresp, rresp}); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        obs_t o; exp_t e;
        do_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, o, e);
        n_cmp++; if (o.to || o.lat != 0) begin n_err++; $display("FAIL wr_latency: got to=%0b lat=%0d want lat=0", o.to, o.lat); end
        n_cmp++; if (o.resp !== e.resp) begin n_err++; $display("FAIL wr_bresp: got %b want %b", o.resp, e.resp); end
        do_read(32'h0000_0010, o, e);
        n_cmp++; if (o.to || o.lat != 0) begin n_err++; $display("FAIL rd_latency: got to=%0b lat=%0d want lat=0", o.to, o.lat); end
        n_cmp++; if (o.resp !== e.resp || o.data !== e.data) begin n_err++; $display("FAIL rd_data: got %b/%h want %b/%h", o.resp, o.data, e.resp, e.data); end
    endtask

    task automatic test_byte_strobe();
        obs_t o; exp_t e;
        do_write(32'h0000_0013, 32'h0000_00AA, 4'b0001, o, e);
        n_cmp++; if (o.to || o.resp !== e.resp) begin n_err++; $display("FAIL strb_bresp: got to=%0b %b want %b", o.to, o.resp, e.resp); end
        do_write(32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, o, e);
        n_cmp++; if (o.to || o.resp !== e.resp) begin n_err++; $display("FAIL strb0_bresp: got to=%0b %b want %b", o.to, o.resp, e.resp); end
        do_read(32'h0000_0010, o, e);
        n_cmp++; if (o.to || o.resp !== e.resp || o.data !== e.data) begin n_err++; $display("FAIL strb_rdata: got %b/%h want %b/%h", o.resp, o.data, e.resp, e.data); end
    endtask

    task automatic test_out_of_range();
        obs_t o; exp_t e;
        do_write(32'h0000_0000, 32'h1122_3344, 4'hF, o, e);
        do_write(32'h0000_3FFC, 32'h55AA_55AA, 4'hF, o, e);
        n_cmp++; if (o.to || o.resp !== e.resp) begin n_err++; $display("FAIL top_word_bresp: got to=%0b %b want %b", o.to, o.resp, e.resp); end
        do_write(32'h0000_4000, 32'hFFFF_FFFF, 4'hF, o, e);
        n_cmp++; if (o.to || o.lat != 0 || o.resp !== e.resp) begin n_err++; $display("FAIL oor_bresp: got to=%0b lat=%0d %b want %b", o.to, o.lat, o.resp, e.resp); end
        do_read(32'h0000_4000, o, e);
        n_cmp++; if (o.to || o.resp !== e.resp || o.data !== e.data) begin n_err++; $display("FAIL oor_read: got %b/%h want %b/%h", o.resp, o.data, e.resp, e.data); end
        do_read(32'h0000_0000, o, e);
        n_cmp++; if (o.to || o.resp !== e.resp || o.data !== e.data) begin n_err++; $display("FAIL oor_no_alias: got %b/%h want %b/%h", o.resp, o.data, e.resp, e.data); end
        do_read(32'h0000_3FFC, o, e);
        n_cmp++; if (o.to || o.resp !== e.resp || o.data !== e.data) begin n_err++; $display("FAIL top_word_read: got %b/%h want %b/%h", o.resp, o.data, e.resp, e.data); end
    endtask

    task automatic test_backpressure();
        obs_t o; exp_t e; bit to_i;
        push_write(32'h0000_0030, 32'hA5A5_0001, 4'hF);
        issue_write(32'h0000_0030, 32'hA5A5_0001, 4'hF, to_i);
        e = sb_q.pop_front();
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; araddr = 32'h30;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (bvalid !== 1'b1 || bresp !== e.resp) begin n_err++; $display("FAIL bp_b_hold[%0d]: got %b/%b want 1/%b", i, bvalid, bresp, e.resp); end
            n_cmp++; if (awready !== 1'b0 || arready !== 1'b0) begin n_err++; $display("FAIL bp_b_ready[%0d]: got aw=%b ar=%b want 0/0", i, awready, arready); end
            tick();
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        collect_b(o);
        n_cmp++; if (to_i || o.to || o.lat != 0) begin n_err++; $display("FAIL bp_b_release: got to=%0b lat=%0d want lat=0", to_i | o.to, o.lat); end
        push_read(32'h0000_0030);
        issue_read(32'h0000_0030, to_i);
        e = sb_q.pop_front();
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (rvalid !== 1'b1 || rresp !== e.resp || rdata !== e.data) begin n_err++; $display("FAIL bp_r_hold[%0d]: got %b/%b/%h want 1/%b/%h", i, rvalid, rresp, rdata, e.resp, e.data); end
            n_cmp++; if (awready !== 1'b0 || arready !== 1'b0) begin n_err++; $display("FAIL bp_r_ready[%0d]: got aw=%b ar=%b want 0/0", i, awready, arready); end
            tick();
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        collect_r(o);
        n_cmp++; if (to_i || o.to || o.data !== e.data) begin n_err++; $display("FAIL bp_r_release: got to=%0b %h want %h", to_i | o.to, o.data, e.data); end
    endtask

    task automatic test_reset_mid_op();
        obs_t o; exp_t e; bit to_i;
        do_write(32'h0000_0040, 32'hCAFE_F00D, 4'hF, o, e);
        push_read(32'h0000_0040);
        issue_read(32'h0000_0040, to_i);
        n_cmp++; if (to_i || rvalid !== 1'b1) begin n_err++; $display("FAIL mid_rvalid_before: got to=%0b rvalid=%b want 1", to_i, rvalid); end
        void'(sb_q.pop_front());
        reset = 1'b0;
        tick();
        arvalid = 1'b1;
        #1;
        n_cmp++; if (rvalid !== 1'b0 || rdata !== 32'h0 || arready !== 1'b0) begin n_err++; $display("FAIL mid_reset_out: got rvalid=%b rdata=%h arready=%b want 0/0/0", rvalid, rdata, arready); end
        arvalid = 1'b0;
        reset = 1'b1;
        tick();
        arvalid = 1'b1;
        #1;
        n_cmp++; if (arready !== 1'b1) begin n_err++; $display("FAIL mid_idle: got arready=%b want 1", arready); end
        arvalid = 1'b0;
        do_read(32'h0000_0040, o, e);
        n_cmp++; if (o.to || o.resp !== e.resp || o.data !== e.data) begin n_err++; $display("FAIL mid_readback: got %b/%h want %b/%h", o.resp, o.data, e.resp, e.data); end
    endtask

    task automatic test_conflict();
        obs_t o; exp_t e;
        apply_reset();
        araddr = 32'h10; awaddr = 32'h24; wdata = 32'h1234_5678; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (k == 1) begin
                n_cmp++; if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b0) begin n_err++; $display("FAIL conflict_grant%0d: got aw=%b w=%b ar=%b want 1/1/0", k, awready, wready, arready); end
                push_write(32'h24, 32'h1234_5678, 4'hF);
                tick();
                collect_b(o);
            end else begin
                n_cmp++; if (arready !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin n_err++; $display("FAIL conflict_grant%0d: got ar=%b aw=%b w=%b want 1/0/0", k, arready, awready, wready); end
                push_read(32'h10);
                tick();
                collect_r(o);
            end
            e = sb_q.pop_front();
            n_cmp++; if (o.to || o.lat != 0 || o.resp !== e.resp || (!e.is_w && o.data !== e.data)) begin n_err++; $display("FAIL conflict_resp%0d: got to=%0b lat=%0d %b/%h want %b/%h", k, o.to, o.lat, o.resp, o.data, e.resp, e.data); end
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        do_read(32'h24, o, e);
        n_cmp++; if (o.to || o.resp !== e.resp || o.data !== e.data) begin n_err++; $display("FAIL conflict_wr_landed: got %b/%h want %b/%h", o.resp, o.data, e.resp, e.data); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        tick();
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_out_of_range();
        test_backpressure();
        test_reset_mid_op();
        test_conflict();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
